// File: rtl/alarm_sequencer_if.sv
// Datapath/player side bundle of the alarm sequencer.
// master drives time, buttons and song_done; slave is the sequencer.
interface alarm_sequencer_if;
  logic       tick_1hz;
  logic       arm;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [5:0] alm_min;
  logic [5:0] alm_sec;
  logic       snooze_btn;
  logic       stop_btn;
  logic       song_done;
  logic       play_en;
  logic       ring_led;
  logic [2:0] state_o;
  logic [1:0] snooze_cnt;
  logic [5:0] snooze_left;

  modport master (
    output tick_1hz, arm,
    output cur_min, cur_sec,
    output alm_min, alm_sec,
    output snooze_btn, stop_btn,
    output song_done,
    input  play_en, ring_led,
    input  state_o, snooze_cnt,
    input  snooze_left
  );

  modport slave (
    input  tick_1hz, arm,
    input  cur_min, cur_sec,
    input  alm_min, alm_sec,
    input  snooze_btn, stop_btn,
    input  song_done,
    output play_en, ring_led,
    output state_o, snooze_cnt,
    output snooze_left
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm control FSM: ring, snooze, stop, ring timeout, same-second lockout.
// Ports: Clock, Resetn (async low), bus (alarm_sequencer_if.slave).
module alarm_sequencer #(
  parameter int SNOOZE_SEC       = 10,
  parameter int RING_TIMEOUT_SEC = 30,
  parameter int MAX_SNOOZE       = 3
) (
  input logic              Clock,
  input logic              Resetn,
  alarm_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMED    = 3'd1,
    RINGING  = 3'd2,
    SNOOZE   = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  localparam logic [5:0] SNZ  = 6'(SNOOZE_SEC);
  localparam logic [5:0] RTO  = 6'(RING_TIMEOUT_SEC);
  localparam logic [1:0] MAXS = 2'(MAX_SNOOZE);

  state_t     state;
  logic       play_en;
  logic       ring_led;
  logic [1:0] snz_cnt;
  logic [5:0] snz_left;
  logic [5:0] ring_tmr;
  logic       snz_q;
  logic       stop_q;

  logic match;
  logic snz_edge;
  logic stop_edge;

  assign match = (bus.cur_min == bus.alm_min)
              && (bus.cur_sec == bus.alm_sec);
  assign snz_edge  = bus.snooze_btn & ~snz_q;
  assign stop_edge = bus.stop_btn & ~stop_q;

  assign bus.play_en     = play_en;
  assign bus.ring_led    = ring_led;
  assign bus.state_o     = state;
  assign bus.snooze_cnt  = snz_cnt;
  assign bus.snooze_left = snz_left;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= DISARMED;
      play_en  <= 1'b0;
      ring_led <= 1'b0;
      snz_cnt  <= '0;
      snz_left <= '0;
      ring_tmr <= '0;
      snz_q    <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      snz_q  <= bus.snooze_btn;
      stop_q <= bus.stop_btn;
      if (!bus.arm) begin
        state    <= DISARMED;
        snz_cnt  <= '0;
        play_en  <= 1'b0;
        ring_led <= 1'b0;
        snz_left <= '0;
        ring_tmr <= '0;
      end else begin
        case (state)
          DISARMED: begin
            play_en  <= 1'b0;
            ring_led <= 1'b0;
            snz_left <= '0;
            // arming inside the alarm second must not ring
            state <= match ? LOCKOUT : ARMED;
          end
          ARMED: begin
            play_en  <= 1'b0;
            ring_led <= 1'b0;
            snz_left <= '0;
            if (match) begin
              state    <= RINGING;
              snz_cnt  <= '0;
              ring_tmr <= '0;
              play_en  <= 1'b1;
              ring_led <= 1'b1;
            end
          end
          RINGING: begin
            if (stop_edge) begin
              state    <= LOCKOUT;
              play_en  <= 1'b0;
              ring_led <= 1'b0;
            end else if (snz_edge && (snz_cnt < MAXS)) begin
              state    <= SNOOZE;
              snz_cnt  <= snz_cnt + 2'd1;
              snz_left <= SNZ;
              play_en  <= 1'b0;
              ring_led <= 1'b0;
            end else if (bus.tick_1hz
                      && (ring_tmr >= RTO - 6'd1)) begin
              state    <= LOCKOUT;
              ring_tmr <= RTO;
              play_en  <= 1'b0;
              ring_led <= 1'b0;
            end else begin
              if (bus.tick_1hz)
                ring_tmr <= ring_tmr + 6'd1;
              // one low cycle restarts the song
              play_en  <= ~bus.song_done;
              ring_led <= 1'b1;
            end
          end
          SNOOZE: begin
            play_en <= 1'b0;
            if (stop_edge) begin
              state    <= LOCKOUT;
              ring_led <= 1'b0;
              snz_left <= '0;
            end else if (bus.tick_1hz) begin
              if (snz_left <= 6'd1) begin
                state    <= RINGING;
                ring_tmr <= '0;
                snz_left <= '0;
                play_en  <= 1'b1;
                ring_led <= 1'b1;
              end else begin
                snz_left <= snz_left - 6'd1;
                ring_led <= ~ring_led;
              end
            end
          end
          LOCKOUT: begin
            play_en  <= 1'b0;
            ring_led <= 1'b0;
            snz_left <= '0;
            if (!match)
              state <= ARMED;
          end
          default: begin
            state    <= DISARMED;
            play_en  <= 1'b0;
            ring_led <= 1'b0;
            snz_left <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with hand-computed expectations.
// Alarm at 00:05; SNOOZE_SEC=10, RING_TIMEOUT_SEC=30, MAX_SNOOZE=3.
module tb_alarm_sequencer;

  logic Clock;
  logic Resetn;
  int   n_chk;
  int   n_fail;

  alarm_sequencer_if bus ();

  alarm_sequencer #(
    .SNOOZE_SEC(10),
    .RING_TIMEOUT_SEC(30),
    .MAX_SNOOZE(3)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .bus(bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1;
    if (bus.cur_sec == 6'd59) begin
      bus.cur_sec = 6'd0;
      bus.cur_min = bus.cur_min + 6'd1;
    end else begin
      bus.cur_sec = bus.cur_sec + 6'd1;
    end
    cyc(1);
    bus.tick_1hz = 1'b0;
  endtask

  task automatic ring_at_five();
    bus.cur_min = 6'd0;
    bus.cur_sec = 6'd4;
    cyc(1);
    tick();
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    cyc(2);
    n_chk++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", bus.state_o); end
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL rst_play got=%0b exp=0", bus.play_en); end
    n_chk++; if (bus.ring_led !== 1'b0) begin n_fail++; $display("FAIL rst_led got=%0b exp=0", bus.ring_led); end
    n_chk++; if (bus.snooze_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", bus.snooze_cnt); end
    n_chk++; if (bus.snooze_left !== 6'd0) begin n_fail++; $display("FAIL rst_left got=%0d exp=0", bus.snooze_left); end
    Resetn = 1'b1;
    cyc(2);
    n_chk++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL disarmed_idle got=%0d exp=0", bus.state_o); end
  endtask

  task automatic test_arm_ring();
    bus.arm = 1'b1;
    cyc(1);
    n_chk++; if (bus.state_o !== 3'd1) begin n_fail++; $display("FAIL arm_state got=%0d exp=1", bus.state_o); end
    repeat (4) tick();
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL pre_ring_play got=%0b exp=0", bus.play_en); end
    n_chk++; if (bus.state_o !== 3'd1) begin n_fail++; $display("FAIL pre_ring_state got=%0d exp=1", bus.state_o); end
    tick();
    n_chk++; if (bus.state_o !== 3'd2) begin n_fail++; $display("FAIL ring_state got=%0d exp=2", bus.state_o); end
    n_chk++; if (bus.play_en !== 1'b1) begin n_fail++; $display("FAIL ring_play got=%0b exp=1", bus.play_en); end
    n_chk++; if (bus.ring_led !== 1'b1) begin n_fail++; $display("FAIL ring_led got=%0b exp=1", bus.ring_led); end
  endtask

  task automatic test_snooze();
    int changes;
    logic prev;
    changes = 0;
    prev = bus.ring_led;
    bus.snooze_btn = 1'b1;
    cyc(1);
    bus.snooze_btn = 1'b0;
    if (bus.ring_led !== prev) changes++;
    prev = bus.ring_led;
    n_chk++; if (bus.state_o !== 3'd3) begin n_fail++; $display("FAIL snz_state got=%0d exp=3", bus.state_o); end
    n_chk++; if (bus.snooze_cnt !== 2'd1) begin n_fail++; $display("FAIL snz_cnt got=%0d exp=1", bus.snooze_cnt); end
    n_chk++; if (bus.snooze_left !== 6'd10) begin n_fail++; $display("FAIL snz_left got=%0d exp=10", bus.snooze_left); end
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL snz_play got=%0b exp=0", bus.play_en); end
    n_chk++; if (bus.ring_led !== 1'b0) begin n_fail++; $display("FAIL snz_led_entry got=%0b exp=0", bus.ring_led); end
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (bus.ring_led !== prev) changes++;
      prev = bus.ring_led;
      n_chk++; if (bus.snooze_left !== 6'(10 - i)) begin n_fail++; $display("FAIL snz_dec%0d got=%0d exp=%0d", i, bus.snooze_left, 10 - i); end
      if (i == 3) begin
        bus.snooze_btn = 1'b1;
        cyc(1);
        bus.snooze_btn = 1'b0;
        n_chk++; if (bus.state_o !== 3'd3) begin n_fail++; $display("FAIL snz_ign_state got=%0d exp=3", bus.state_o); end
        n_chk++; if (bus.snooze_cnt !== 2'd1) begin n_fail++; $display("FAIL snz_ign_cnt got=%0d exp=1", bus.snooze_cnt); end
        n_chk++; if (bus.snooze_left !== 6'd7) begin n_fail++; $display("FAIL snz_ign_left got=%0d exp=7", bus.snooze_left); end
      end
    end
    n_chk++; if (bus.state_o !== 3'd3) begin n_fail++; $display("FAIL snz_last_state got=%0d exp=3", bus.state_o); end
    tick();
    if (bus.ring_led !== prev) changes++;
    n_chk++; if (bus.state_o !== 3'd2) begin n_fail++; $display("FAIL snz_exp_state got=%0d exp=2", bus.state_o); end
    n_chk++; if (bus.play_en !== 1'b1) begin n_fail++; $display("FAIL snz_exp_play got=%0b exp=1", bus.play_en); end
    n_chk++; if (bus.snooze_left !== 6'd0) begin n_fail++; $display("FAIL snz_exp_left got=%0d exp=0", bus.snooze_left); end
    n_chk++; if (changes != 10) begin n_fail++; $display("FAIL snz_led_toggles got=%0d exp=10", changes); end
  endtask

  task automatic test_max_snooze();
    for (int k = 2; k <= 3; k++) begin
      bus.snooze_btn = 1'b1;
      cyc(1);
      bus.snooze_btn = 1'b0;
      n_chk++; if (bus.snooze_cnt !== 2'(k)) begin n_fail++; $display("FAIL max_cnt%0d got=%0d exp=%0d", k, bus.snooze_cnt, k); end
      repeat (10) tick();
      n_chk++; if (bus.state_o !== 3'd2) begin n_fail++; $display("FAIL max_ring%0d got=%0d exp=2", k, bus.state_o); end
    end
    bus.snooze_btn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(1);
      n_chk++; if (bus.state_o !== 3'd2) begin n_fail++; $display("FAIL max_4th_state got=%0d exp=2", bus.state_o); end
      n_chk++; if (bus.play_en !== 1'b1) begin n_fail++; $display("FAIL max_4th_play got=%0b exp=1", bus.play_en); end
    end
    bus.snooze_btn = 1'b0;
    n_chk++; if (bus.snooze_cnt !== 2'd3) begin n_fail++; $display("FAIL max_4th_cnt got=%0d exp=3", bus.snooze_cnt); end
  endtask

  task automatic test_timeout();
    repeat (29) tick();
    n_chk++; if (bus.state_o !== 3'd2) begin n_fail++; $display("FAIL to_29_state got=%0d exp=2", bus.state_o); end
    n_chk++; if (bus.play_en !== 1'b1) begin n_fail++; $display("FAIL to_29_play got=%0b exp=1", bus.play_en); end
    tick();
    n_chk++; if (bus.state_o !== 3'd4) begin n_fail++; $display("FAIL to_30_state got=%0d exp=4", bus.state_o); end
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL to_30_play got=%0b exp=0", bus.play_en); end
    cyc(1);
    n_chk++; if (bus.state_o !== 3'd1) begin n_fail++; $display("FAIL to_rearm got=%0d exp=1", bus.state_o); end
    n_chk++; if (bus.snooze_cnt !== 2'd3) begin n_fail++; $display("FAIL to_cnt_held got=%0d exp=3", bus.snooze_cnt); end
  endtask

  task automatic test_lockout_same_second();
    ring_at_five();
    n_chk++; if (bus.snooze_cnt !== 2'd0) begin n_fail++; $display("FAIL lk_cnt_clr got=%0d exp=0", bus.snooze_cnt); end
    bus.stop_btn = 1'b1;
    cyc(1);
    n_chk++; if (bus.state_o !== 3'd4) begin n_fail++; $display("FAIL lk_stop got=%0d exp=4", bus.state_o); end
    cyc(3);
    bus.stop_btn = 1'b0;
    n_chk++; if (bus.state_o !== 3'd4) begin n_fail++; $display("FAIL lk_hold got=%0d exp=4", bus.state_o); end
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL lk_play got=%0b exp=0", bus.play_en); end
    tick();
    n_chk++; if (bus.state_o !== 3'd1) begin n_fail++; $display("FAIL lk_rearm got=%0d exp=1", bus.state_o); end
  endtask

  task automatic test_stop_and_snooze();
    ring_at_five();
    bus.snooze_btn = 1'b1;
    cyc(1);
    bus.snooze_btn = 1'b0;
    repeat (10) tick();
    n_chk++; if (bus.state_o !== 3'd2) begin n_fail++; $display("FAIL ss_ring got=%0d exp=2", bus.state_o); end
    bus.snooze_btn = 1'b1;
    bus.stop_btn   = 1'b1;
    cyc(1);
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
    n_chk++; if (bus.state_o !== 3'd4) begin n_fail++; $display("FAIL ss_state got=%0d exp=4", bus.state_o); end
    n_chk++; if (bus.snooze_cnt !== 2'd1) begin n_fail++; $display("FAIL ss_cnt got=%0d exp=1", bus.snooze_cnt); end
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL ss_play got=%0b exp=0", bus.play_en); end
    cyc(1);
    n_chk++; if (bus.state_o !== 3'd1) begin n_fail++; $display("FAIL ss_rearm got=%0d exp=1", bus.state_o); end
  endtask

  task automatic test_stop_beats_expiry();
    ring_at_five();
    bus.snooze_btn = 1'b1;
    cyc(1);
    bus.snooze_btn = 1'b0;
    repeat (9) tick();
    n_chk++; if (bus.snooze_left !== 6'd1) begin n_fail++; $display("FAIL se_left got=%0d exp=1", bus.snooze_left); end
    bus.stop_btn = 1'b1;
    tick();
    bus.stop_btn = 1'b0;
    n_chk++; if (bus.state_o !== 3'd4) begin n_fail++; $display("FAIL se_state got=%0d exp=4", bus.state_o); end
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL se_play got=%0b exp=0", bus.play_en); end
    n_chk++; if (bus.snooze_left !== 6'd0) begin n_fail++; $display("FAIL se_left0 got=%0d exp=0", bus.snooze_left); end
    cyc(1);
  endtask

  task automatic test_song_done();
    ring_at_five();
    cyc(1);
    bus.song_done = 1'b1;
    cyc(1);
    bus.song_done = 1'b0;
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL sd_low got=%0b exp=0", bus.play_en); end
    n_chk++; if (bus.state_o !== 3'd2) begin n_fail++; $display("FAIL sd_state got=%0d exp=2", bus.state_o); end
    cyc(1);
    n_chk++; if (bus.play_en !== 1'b1) begin n_fail++; $display("FAIL sd_high got=%0b exp=1", bus.play_en); end
    bus.stop_btn = 1'b1;
    cyc(1);
    bus.stop_btn = 1'b0;
    tick();
  endtask

  task automatic test_disarm();
    ring_at_five();
    bus.arm = 1'b0;
    cyc(1);
    n_chk++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL dis_state got=%0d exp=0", bus.state_o); end
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL dis_play got=%0b exp=0", bus.play_en); end
    n_chk++; if (bus.ring_led !== 1'b0) begin n_fail++; $display("FAIL dis_led got=%0b exp=0", bus.ring_led); end
    bus.arm = 1'b1;
    cyc(1);
    n_chk++; if (bus.state_o !== 3'd4) begin n_fail++; $display("FAIL arm_in_match got=%0d exp=4", bus.state_o); end
    tick();
    n_chk++; if (bus.state_o !== 3'd1) begin n_fail++; $display("FAIL dis_rearm got=%0d exp=1", bus.state_o); end
  endtask

  task automatic test_reset_mid_snooze();
    ring_at_five();
    Resetn = 1'b0;
    #2;
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL rr_play got=%0b exp=0", bus.play_en); end
    Resetn = 1'b1;
    cyc(1);
    ring_at_five();
    bus.snooze_btn = 1'b1;
    cyc(1);
    bus.snooze_btn = 1'b0;
    tick();
    n_chk++; if (bus.ring_led !== 1'b1) begin n_fail++; $display("FAIL rs_pre_led got=%0b exp=1", bus.ring_led); end
    Resetn = 1'b0;
    #2;
    n_chk++; if (bus.state_o !== 3'd0) begin n_fail++; $display("FAIL rs_state got=%0d exp=0", bus.state_o); end
    n_chk++; if (bus.ring_led !== 1'b0) begin n_fail++; $display("FAIL rs_led got=%0b exp=0", bus.ring_led); end
    n_chk++; if (bus.snooze_cnt !== 2'd0) begin n_fail++; $display("FAIL rs_cnt got=%0d exp=0", bus.snooze_cnt); end
    n_chk++; if (bus.snooze_left !== 6'd0) begin n_fail++; $display("FAIL rs_left got=%0d exp=0", bus.snooze_left); end
    n_chk++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL rs_play got=%0b exp=0", bus.play_en); end
    Resetn = 1'b1;
    cyc(1);
    n_chk++; if (bus.state_o !== 3'd1) begin n_fail++; $display("FAIL rs_rearm got=%0d exp=1", bus.state_o); end
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    Resetn         = 1'b0;
    bus.tick_1hz   = 1'b0;
    bus.arm        = 1'b0;
    bus.cur_min    = 6'd0;
    bus.cur_sec    = 6'd0;
    bus.alm_min    = 6'd0;
    bus.alm_sec    = 6'd5;
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
    bus.song_done  = 1'b0;
    test_reset();
    test_arm_ring();
    test_snooze();
    test_max_snooze();
    test_timeout();
    test_lockout_same_second();
    test_stop_and_snooze();
    test_stop_beats_expiry();
    test_song_done();
    test_disarm();
    test_reset_mid_snooze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
